// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Receive-side PWM measurement. The asynchronous PWM input is synchronized,
//   and its rising edges are found. For every frame, which runs from one rising
//   edge up to the cycle before the next one, the block reports:
//     - the number of cycles in the frame (period), and
//     - the number of those cycles in which the synchronized input was high.
//   Both values are reported together with a one-cycle valid strobe.
//   If no closing edge arrives, the frame is closed at the counter limit with a
//   timeout strobe, and the decoder returns to idle.
//
// Parameters
//   CNT_W     width of the counters and of the measured outputs
//   SYNC_LEN  input synchronizer depth in flops (2..3)
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-high
//   en         decoder enable; low abandons any open frame
//   pwm_i      PWM waveform, asynchronous to clk
//   high_o     high cycles in the last completed frame
//   period_o   total cycles in the last completed frame
//   valid_o    one-cycle strobe: high_o/period_o updated
//   timeout_o  one-cycle strobe alongside valid_o: frame closed by timeout
module pwm_decoder #(
  parameter int CNT_W    = 16,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_LEN-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]    high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]    high_q, high_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;

  logic                s_in;
  logic                rise;
  logic                at_limit;

  // Synchronized level, its one-cycle-old copy, and the derived edge / limit flags
  always_comb begin
    sync_d   = {sync_q[SYNC_LEN-2:0], pwm_i};
    s_in     = sync_q[SYNC_LEN-1];
    prev_d   = s_in;
    rise     = s_in & ~prev_q;
    at_limit = (period_cnt_q == CNT_MAX);
  end

  // Next-state logic: rise beats timeout, and a low enable always wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en && rise) begin
          state_d = MEASURE;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEASURE;
        end else if (at_limit) begin
          state_d = IDLE;
        end else begin
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and result computation; the results only move when a strobe is raised
  always_comb begin
    period_cnt_d = CNT_ZERO;
    high_cnt_d   = CNT_ZERO;
    high_d       = high_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // The first edge only opens a frame. That edge cycle already counts,
        // both as a frame cycle and as a high cycle.
        if (en && rise) begin
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else begin
          period_cnt_d = CNT_ZERO;
          high_cnt_d   = CNT_ZERO;
        end
      end
      MEASURE: begin
        if (!en) begin
          period_cnt_d = CNT_ZERO;
          high_cnt_d   = CNT_ZERO;
        end else if (rise) begin
          // Close the frame and open the next one in the same cycle, so no
          // cycle is lost between back-to-back frames.
          high_d       = high_cnt_q;
          period_d     = period_cnt_q;
          valid_d      = 1'b1;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else if (at_limit) begin
          high_d       = high_cnt_q;
          period_d     = CNT_MAX;
          valid_d      = 1'b1;
          timeout_d    = 1'b1;
          period_cnt_d = CNT_ZERO;
          high_cnt_d   = CNT_ZERO;
        end else begin
          // high_cnt never exceeds period_cnt, so neither counter can wrap
          // before the limit check above fires.
          period_cnt_d = period_cnt_q + CNT_ONE;
          high_cnt_d   = high_cnt_q + {{(CNT_W-1){1'b0}}, s_in};
        end
      end
      default: begin
        period_cnt_d = CNT_ZERO;
        high_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, synchronizer, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= {SYNC_LEN{1'b0}};
      prev_q       <= 1'b0;
      state_q      <= IDLE;
      period_cnt_q <= CNT_ZERO;
      high_cnt_q   <= CNT_ZERO;
      high_q       <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      high_q       <= high_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign high_o    = high_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
//   Drives two decoders from the same stimulus: a 16-bit one and an 8-bit one.
//   The 8-bit decoder can reach its timeout within a short run.
//
//   The reference model records the synchronized input level for every cycle,
//   together with a running prefix sum of that level. When a frame closes:
//     - its period is the difference of two cycle indices, and
//     - its high time is the difference of two prefix sums.
//   Every cycle, both decoders' outputs are compared against the model.
module tb_pwm_decoder;

  localparam int SL   = 2;
  localparam int NMAX = 40000;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic        pwm_i = 1'b0;

  logic [15:0] a_high, a_period;
  logic        a_valid, a_timeout;
  logic [7:0]  b_high, b_period;
  logic        b_valid, b_timeout;

  int          samp [NMAX];  // pwm_i value captured at edge n
  int          cum  [NMAX];  // sum of synchronized level over cycles 0..n-1
  int          k;
  int          prev_s;
  int          checks;
  int          errors;

  int          open_m [2];
  int          fs     [2];
  int          eh     [2];
  int          ep     [2];
  int          ev     [2];
  int          et     [2];
  int          mx     [2] = '{65535, 255};

  pwm_decoder #(.CNT_W(16), .SYNC_LEN(SL)) dut_a (
    .clk(clk), .rst(rst), .en(en), .pwm_i(pwm_i),
    .high_o(a_high), .period_o(a_period), .valid_o(a_valid), .timeout_o(a_timeout)
  );

  pwm_decoder #(.CNT_W(8), .SYNC_LEN(SL)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pwm_i(pwm_i),
    .high_o(b_high), .period_o(b_period), .valid_o(b_valid), .timeout_o(b_timeout)
  );

  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("a_valid",   {31'd0, a_valid},   ev[0]);
    check_eq("a_timeout", {31'd0, a_timeout}, et[0]);
    check_eq("a_high",    {16'd0, a_high},    eh[0]);
    check_eq("a_period",  {16'd0, a_period},  ep[0]);
    check_eq("b_valid",   {31'd0, b_valid},   ev[1]);
    check_eq("b_timeout", {31'd0, b_timeout}, et[1]);
    check_eq("b_high",    {24'd0, b_high},    eh[1]);
    check_eq("b_period",  {24'd0, b_period},  ep[1]);
  endtask

  task automatic clear_model();
    prev_s = 0;
    for (int i = 0; i < 2; i++) begin
      open_m[i] = 0; fs[i] = 0; eh[i] = 0; ep[i] = 0; ev[i] = 0; et[i] = 0;
    end
  endtask

  // One clock cycle: optional mid-cycle reset pulse, drive inputs, model, check
  task automatic step(input bit p, input bit e, input bit in_rst, input bit pulse);
    int s;
    bit rise;
    if (k + 2 >= NMAX) begin
      $display("FAIL cycle_budget obs=%0d exp<%0d", k, NMAX);
      $fatal(1, "cycle budget exceeded");
    end
    if (pulse) begin
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      check_eq("pulse_a_high",   {16'd0, a_high},   0);
      check_eq("pulse_a_period", {16'd0, a_period}, 0);
      check_eq("pulse_a_valid",  {31'd0, a_valid},  0);
      check_eq("pulse_b_high",   {24'd0, b_high},   0);
      check_eq("pulse_b_period", {24'd0, b_period}, 0);
      for (int j = k - 3; j <= k; j++) if (j >= 0) samp[j] = 0;
      clear_model();
    end
    rst   = in_rst;
    pwm_i = p;
    en    = e;
    samp[k+1] = in_rst ? 0 : int'(p);
    s = (k - SL + 1 >= 0 && !in_rst) ? samp[k-SL+1] : 0;
    cum[k+1] = cum[k] + s;
    rise = (s == 1) && (prev_s == 0);
    prev_s = s;
    if (in_rst) begin
      clear_model();
    end else begin
      for (int i = 0; i < 2; i++) begin
        ev[i] = 0;
        et[i] = 0;
        if (!e) begin
          open_m[i] = 0;
        end else if (rise) begin
          if (open_m[i] != 0) begin
            eh[i] = cum[k] - cum[fs[i]];
            ep[i] = k - fs[i];
            ev[i] = 1;
          end
          open_m[i] = 1;
          fs[i] = k;
        end else if (open_m[i] != 0 && (k - fs[i]) == mx[i]) begin
          eh[i] = cum[k] - cum[fs[i]];
          ep[i] = mx[i];
          ev[i] = 1;
          et[i] = 1;
          open_m[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
    k++;
  endtask

  task automatic frame(input int hi, input int per, input int drop_at, input int drop_len,
                       input int rst_at);
    for (int c = 0; c < per; c++)
      step(c < hi, !(c >= drop_at && c < drop_at + drop_len), 1'b0, c == rst_at);
  endtask

  initial begin
    int per;
    int hi;
    checks = 0;
    errors = 0;
    k = 0;
    clear_model();
    for (int i = 0; i < NMAX; i++) begin
      samp[i] = 0;
      cum[i]  = 0;
    end

    @(posedge clk);
    #1;
    check_all();

    // reset held with pwm toggling, then release
    for (int i = 0; i < 6; i++) step(i[0], 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frame(0, 10, -1, 0, -1);

    // steady 64/256
    for (int i = 0; i < 5; i++) frame(64, 256, -1, 0, -1);

    // duty step
    for (int i = 0; i < 2; i++) frame(16, 256, -1, 0, -1);
    for (int i = 0; i < 2; i++) frame(240, 256, -1, 0, -1);

    // one rise then held high: 8-bit decoder times out
    frame(300, 300, -1, 0, -1);
    frame(0, 20, -1, 0, -1);

    // enable drop mid-frame
    frame(64, 256, -1, 0, -1);
    frame(64, 256, 100, 10, -1);
    for (int i = 0; i < 3; i++) frame(64, 256, -1, 0, -1);

    // async reset pulse mid-frame
    for (int i = 0; i < 2; i++) frame(64, 256, -1, 0, -1);
    frame(64, 256, -1, 0, 100);
    for (int i = 0; i < 3; i++) frame(64, 256, -1, 0, -1);

    // rise coinciding with 8-bit timeout
    for (int i = 0; i < 3; i++) frame(100, 255, -1, 0, -1);

    // randomized frames with occasional enable drops and reset pulses
    for (int n = 0; n < 30; n++) begin
      per = $urandom_range(2, 500);
      if ($urandom_range(0, 5) == 0) per = 255;
      hi = $urandom_range(1, per - 1);
      frame(hi, per,
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, per - 1)) : -1,
            int'($urandom_range(1, 20)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, per - 1)) : -1);
    end
    frame(50, 100, -1, 0, -1);
    frame(50, 100, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
